// File: rtl/onehot_stream_checker.sv
// onehot_stream_checker: two-stage population-rule checker with saturating sample/error counters
module onehot_stream_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 16,
  localparam int PW = $clog2(DATA_WIDTH + 1),
  localparam int IW = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [1:0]            mode,
  input  logic                  clear,
  output logic                  dout_valid,
  output logic [PW-1:0]         popcount,
  output logic                  match,
  output logic [IW-1:0]         index,
  output logic [CNT_WIDTH-1:0]  sample_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_sticky
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  logic [PW-1:0] pop_c, s1_pop;
  logic [IW-1:0] lo1_c, lo0_c, s1_lo1, s1_lo0, idx_c;
  logic [1:0] s1_mode;
  logic s1_valid, match_c;
  logic [CNT_WIDTH-1:0] sample_base, err_base;
  // population count plus lowest set and lowest clear bit positions (scan downward so the lowest wins)
  always_comb begin
    pop_c = '0;
    lo1_c = '0;
    lo0_c = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      pop_c = pop_c + PW'(din[i]);
      if (din[i]) lo1_c = IW'(i);
      else lo0_c = IW'(i);
    end
  end
  // stage 1: capture per-word statistics and the rule selected for that word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_pop <= '0;
      s1_lo1 <= '0;
      s1_lo0 <= '0;
      s1_mode <= '0;
    end else begin
      s1_valid <= din_valid;
      if (din_valid) begin
        s1_pop <= pop_c;
        s1_lo1 <= lo1_c;
        s1_lo0 <= lo0_c;
        s1_mode <= mode;
      end
    end
  end
  // rule evaluation; mode picks whether the hot or the cold position is reported
  always_comb begin
    match_c = s1_mode == 2'd0 ? s1_pop == PW'(1) :
              s1_mode == 2'd1 ? s1_pop == PW'(DATA_WIDTH - 1) :
              s1_mode == 2'd2 ? s1_pop <= PW'(1) : s1_pop == '0;
    idx_c = (match_c && !s1_mode[0] && s1_pop == PW'(1)) ? s1_lo1 :
            (match_c && s1_mode == 2'd1) ? s1_lo0 : '0;
    sample_base = clear ? '0 : sample_count;
    err_base = clear ? '0 : err_count;
  end
  // stage 2: result outputs hold their last values between valid words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_valid <= 1'b0;
      popcount <= '0;
      match <= 1'b0;
      index <= '0;
    end else begin
      dout_valid <= s1_valid;
      if (s1_valid) begin
        popcount <= s1_pop;
        match <= match_c;
        index <= idx_c;
      end
    end
  end
  // counters: clear takes effect first, then the result on this edge is counted, saturating at max
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_count <= '0;
      err_count <= '0;
      err_sticky <= 1'b0;
    end else begin
      sample_count <= sample_base + CNT_WIDTH'(s1_valid && sample_base != CNT_MAX);
      err_count <= err_base + CNT_WIDTH'(s1_valid && !match_c && err_base != CNT_MAX);
      err_sticky <= (err_sticky && !clear) || (s1_valid && !match_c);
    end
  end
endmodule

// File: tb/tb_onehot_stream_checker.sv
// tb_onehot_stream_checker: directed and scoreboard checks across 8-, 8/2-, 32- and 2-bit instances
module tb_onehot_stream_checker;
  logic clk = 1'b0, reset = 1'b1, din_valid = 1'b0, clear = 1'b0;
  logic [31:0] din = '0;
  logic [1:0] mode = '0;
  int n_chk = 0, n_err = 0;
  logic dv8, m8, st8, dvc, mc, stc, dv32, m32, st32, dv2, m2, st2;
  logic [3:0] pc8, pcc;
  logic [2:0] ix8, ixc;
  logic [15:0] sc8, ec8, sc32, ec32, sc2, ec2;
  logic [1:0] scc, ecc, pc2;
  logic [5:0] pc32;
  logic [4:0] ix32;
  logic [0:0] ix2;

  always #5 clk = ~clk;

  onehot_stream_checker #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u8 (.clk(clk), .reset(reset), .din_valid(din_valid), .din(din[7:0]), .mode(mode), .clear(clear),
    .dout_valid(dv8), .popcount(pc8), .match(m8), .index(ix8), .sample_count(sc8), .err_count(ec8), .err_sticky(st8));
  onehot_stream_checker #(.DATA_WIDTH(8), .CNT_WIDTH(2)) u8c (.clk(clk), .reset(reset), .din_valid(din_valid), .din(din[7:0]), .mode(mode), .clear(clear),
    .dout_valid(dvc), .popcount(pcc), .match(mc), .index(ixc), .sample_count(scc), .err_count(ecc), .err_sticky(stc));
  onehot_stream_checker #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u32 (.clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .mode(mode), .clear(clear),
    .dout_valid(dv32), .popcount(pc32), .match(m32), .index(ix32), .sample_count(sc32), .err_count(ec32), .err_sticky(st32));
  onehot_stream_checker #(.DATA_WIDTH(2), .CNT_WIDTH(16)) u2 (.clk(clk), .reset(reset), .din_valid(din_valid), .din(din[1:0]), .mode(mode), .clear(clear),
    .dout_valid(dv2), .popcount(pc2), .match(m2), .index(ix2), .sample_count(sc2), .err_count(ec2), .err_sticky(st2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input logic [31:0] d, input logic [1:0] m);
    din = d;
    mode = m;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_chk++; if (dv8 !== 1'b0) begin n_err++; $display("FAIL rst_dv got %0d exp 0", dv8); end
    n_chk++; if (pc8 !== 4'd0) begin n_err++; $display("FAIL rst_pop got %0d exp 0", pc8); end
    n_chk++; if (sc8 !== 16'd0 || ec8 !== 16'd0 || st8 !== 1'b0) begin n_err++; $display("FAIL rst_cnt got %0d/%0d/%0d exp 0/0/0", sc8, ec8, st8); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_onehot_basic();
    din = 32'h10;
    mode = 2'd0;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    n_chk++; if (dv8 !== 1'b0) begin n_err++; $display("FAIL lat_early got %0d exp 0", dv8); end
    tick();
    n_chk++; if (dv8 !== 1'b1) begin n_err++; $display("FAIL basic_dv got %0d exp 1", dv8); end
    n_chk++; if (pc8 !== 4'd1 || m8 !== 1'b1 || ix8 !== 3'd4) begin n_err++; $display("FAIL basic_res got pop=%0d m=%0d ix=%0d exp 1/1/4", pc8, m8, ix8); end
    n_chk++; if (sc8 !== 16'd1 || ec8 !== 16'd0) begin n_err++; $display("FAIL basic_cnt got %0d/%0d exp 1/0", sc8, ec8); end
    tick();
    n_chk++; if (dv8 !== 1'b0) begin n_err++; $display("FAIL basic_dv_drop got %0d exp 0", dv8); end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    mode = 2'd0;
    din_valid = 1'b1;
    din = 32'h00;
    tick();
    din = 32'h03;
    tick();
    n_chk++; if (dv8 !== 1'b1 || m8 !== 1'b0 || ix8 !== 3'd0 || pc8 !== 4'd0) begin n_err++; $display("FAIL b2b_0 got dv=%0d m=%0d ix=%0d pop=%0d exp 1/0/0/0", dv8, m8, ix8, pc8); end
    din = 32'h80;
    tick();
    n_chk++; if (dv8 !== 1'b1 || m8 !== 1'b0 || ix8 !== 3'd0 || pc8 !== 4'd2) begin n_err++; $display("FAIL b2b_1 got dv=%0d m=%0d ix=%0d pop=%0d exp 1/0/0/2", dv8, m8, ix8, pc8); end
    din_valid = 1'b0;
    tick();
    n_chk++; if (dv8 !== 1'b1 || m8 !== 1'b1 || ix8 !== 3'd7 || pc8 !== 4'd1) begin n_err++; $display("FAIL b2b_2 got dv=%0d m=%0d ix=%0d pop=%0d exp 1/1/7/1", dv8, m8, ix8, pc8); end
    n_chk++; if (sc8 !== 16'd3 || ec8 !== 16'd2 || st8 !== 1'b1) begin n_err++; $display("FAIL b2b_cnt got %0d/%0d/%0d exp 3/2/1", sc8, ec8, st8); end
    tick();
    n_chk++; if (dv8 !== 1'b0 || pc8 !== 4'd1 || ix8 !== 3'd7 || m8 !== 1'b1) begin n_err++; $display("FAIL b2b_hold got dv=%0d pop=%0d ix=%0d m=%0d exp 0/1/7/1", dv8, pc8, ix8, m8); end
  endtask

  task automatic test_modes();
    run_word(32'hFB, 2'd1);
    n_chk++; if (m8 !== 1'b1 || ix8 !== 3'd2 || pc8 !== 4'd7) begin n_err++; $display("FAIL cold got m=%0d ix=%0d pop=%0d exp 1/2/7", m8, ix8, pc8); end
    run_word(32'h00, 2'd2);
    n_chk++; if (m8 !== 1'b1 || ix8 !== 3'd0) begin n_err++; $display("FAIL zoh_zero got m=%0d ix=%0d exp 1/0", m8, ix8); end
    run_word(32'h20, 2'd2);
    n_chk++; if (m8 !== 1'b1 || ix8 !== 3'd5) begin n_err++; $display("FAIL zoh_one got m=%0d ix=%0d exp 1/5", m8, ix8); end
    run_word(32'h01, 2'd3);
    n_chk++; if (m8 !== 1'b0 || ix8 !== 3'd0) begin n_err++; $display("FAIL allzero got m=%0d ix=%0d exp 0/0", m8, ix8); end
    run_word(32'hFFFF_FFFF, 2'd0);
    n_chk++; if (pc32 !== 6'd32 || m32 !== 1'b0 || ix32 !== 5'd0) begin n_err++; $display("FAIL ones32 got pop=%0d m=%0d ix=%0d exp 32/0/0", pc32, m32, ix32); end
    n_chk++; if (pc8 !== 4'd8) begin n_err++; $display("FAIL ones8 got %0d exp 8", pc8); end
    run_word(32'h2, 2'd1);
    n_chk++; if (m2 !== 1'b1 || ix2 !== 1'b0 || pc2 !== 2'd1) begin n_err++; $display("FAIL w2_cold got m=%0d ix=%0d pop=%0d exp 1/0/1", m2, ix2, pc2); end
    run_word(32'h2, 2'd0);
    n_chk++; if (m2 !== 1'b1 || ix2 !== 1'b1) begin n_err++; $display("FAIL w2_hot got m=%0d ix=%0d exp 1/1", m2, ix2); end
  endtask

  task automatic test_mode_capture();
    din = 32'h10;
    mode = 2'd0;
    din_valid = 1'b1;
    tick();
    mode = 2'd3;
    tick();
    din_valid = 1'b0;
    n_chk++; if (m8 !== 1'b1 || ix8 !== 3'd4) begin n_err++; $display("FAIL cap_first got m=%0d ix=%0d exp 1/4", m8, ix8); end
    tick();
    n_chk++; if (m8 !== 1'b0 || ix8 !== 3'd0) begin n_err++; $display("FAIL cap_second got m=%0d ix=%0d exp 0/0", m8, ix8); end
  endtask

  task automatic test_saturate_clear();
    pulse_clear();
    n_chk++; if (scc !== 2'd0 || ecc !== 2'd0 || stc !== 1'b0) begin n_err++; $display("FAIL clr_alone got %0d/%0d/%0d exp 0/0/0", scc, ecc, stc); end
    din = 32'h01;
    mode = 2'd3;
    din_valid = 1'b1;
    repeat (6) tick();
    din_valid = 1'b0;
    tick();
    tick();
    n_chk++; if (scc !== 2'd3 || ecc !== 2'd3 || stc !== 1'b1) begin n_err++; $display("FAIL sat got %0d/%0d/%0d exp 3/3/1", scc, ecc, stc); end
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_chk++; if (dvc !== 1'b1 || scc !== 2'd1 || ecc !== 2'd1 || stc !== 1'b1) begin n_err++; $display("FAIL clr_hit got dv=%0d %0d/%0d/%0d exp 1 1/1/1", dvc, scc, ecc, stc); end
    din = 32'h04;
    mode = 2'd0;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_chk++; if (scc !== 2'd1 || ecc !== 2'd0 || stc !== 1'b0) begin n_err++; $display("FAIL clr_hit_ok got %0d/%0d/%0d exp 1/0/0", scc, ecc, stc); end
  endtask

  task automatic test_async_reset();
    din = 32'h10;
    mode = 2'd0;
    din_valid = 1'b1;
    tick();
    din = 32'h20;
    tick();
    din_valid = 1'b0;
    n_chk++; if (dv8 !== 1'b1 || sc8 === 16'd0) begin n_err++; $display("FAIL ar_pre got dv=%0d sc=%0d exp 1/nonzero", dv8, sc8); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (dv8 !== 1'b0 || pc8 !== 4'd0 || ix8 !== 3'd0 || sc8 !== 16'd0 || ec8 !== 16'd0) begin n_err++; $display("FAIL ar_now got dv=%0d pop=%0d ix=%0d sc=%0d ec=%0d exp zeros", dv8, pc8, ix8, sc8, ec8); end
    tick();
    #3 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (dv8 !== 1'b0 || sc8 !== 16'd0) begin n_err++; $display("FAIL ar_post%0d got dv=%0d sc=%0d exp 0/0", i, dv8, sc8); end
    end
  endtask

  task automatic test_random();
    localparam int N = 300;
    logic v [N+1];
    logic [31:0] d [N+1];
    logic [1:0] md [N+1];
    int exp_s = 0, exp_e = 0, pc;
    logic exp_m;
    logic [4:0] exp_ix;
    pulse_clear();
    for (int c = 0; c <= N; c++) begin
      int r = $urandom_range(0, 3);
      logic [31:0] one = 32'h1 << $urandom_range(0, 31);
      v[c] = (c < N) && ($urandom_range(0, 3) != 0);
      d[c] = r == 0 ? one : r == 1 ? ~one : r == 2 ? 32'h0 : $urandom;
      md[c] = 2'($urandom_range(0, 3));
      din_valid = v[c];
      din = d[c];
      mode = md[c];
      tick();
      if (c > 0) begin
        n_chk++; if (dv32 !== v[c-1]) begin n_err++; $display("FAIL rnd_dv c=%0d got %0d exp %0d", c, dv32, v[c-1]); end
        if (v[c-1]) begin
          pc = $countones(d[c-1]);
          exp_m = md[c-1] == 0 ? pc == 1 : md[c-1] == 1 ? pc == 31 : md[c-1] == 2 ? pc <= 1 : pc == 0;
          exp_ix = '0;
          if (exp_m && md[c-1] != 2'd3)
            for (int i = 31; i >= 0; i--) if (md[c-1] == 2'd1 ? !d[c-1][i] : d[c-1][i]) exp_ix = 5'(i);
          exp_s++;
          if (!exp_m) exp_e++;
          n_chk++; if (pc32 !== 6'(pc) || m32 !== exp_m || ix32 !== exp_ix) begin n_err++; $display("FAIL rnd_res c=%0d d=%h md=%0d got pop=%0d m=%0d ix=%0d exp %0d/%0d/%0d", c, d[c-1], md[c-1], pc32, m32, ix32, pc, exp_m, exp_ix); end
        end
      end
    end
    din_valid = 1'b0;
    tick();
    n_chk++; if (sc32 !== 16'(exp_s) || ec32 !== 16'(exp_e) || st32 !== (exp_e != 0)) begin n_err++; $display("FAIL rnd_cnt got %0d/%0d/%0d exp %0d/%0d/%0d", sc32, ec32, st32, exp_s, exp_e, exp_e != 0); end
  endtask

  initial begin
    test_reset();
    test_onehot_basic();
    test_back_to_back();
    test_modes();
    test_mode_capture();
    test_saturate_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
